// File: rtl/decod_regfile_alu.sv
// Operand-issue stage in front of the ALU: decodes RV32I R/I-type ALU ops,
// reads the register file with write-back bypass, tracks in-flight
// destinations in a busy scoreboard and presents operands from a registered
// valid/ready output stage.
module decod_regfile_alu #(
    parameter int unsigned XLEN = 32,
    parameter int unsigned NREG = 32
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            inst_valid,
    input  logic [31:0]     inst,
    output logic            inst_ready,
    output logic [XLEN-1:0] rs1,
    output logic [XLEN-1:0] rs2,
    output logic [2:0]      sel,
    output logic [4:0]      rd_out,
    output logic            op_valid,
    input  logic            op_ready,
    input  logic            wb_en,
    input  logic [4:0]      wb_rd,
    input  logic [XLEN-1:0] wb_data,
    output logic            illegal
);

    typedef enum logic [2:0] {
        SEL_ADD = 3'd0,
        SEL_SUB = 3'd1,
        SEL_AND = 3'd2,
        SEL_OR  = 3'd3,
        SEL_XOR = 3'd4,
        SEL_SLL = 3'd5,
        SEL_SRL = 3'd6,
        SEL_SLT = 3'd7
    } alu_sel_e;

    typedef enum logic [6:0] {
        OPC_OP     = 7'b0110011,
        OPC_OP_IMM = 7'b0010011
    } opcode_e;

    // Instruction fields
    logic [6:0] opcode;
    logic [2:0] funct3;
    logic [6:0] funct7;
    logic [4:0] rs1_idx;
    logic [4:0] rs2_idx;
    logic [4:0] rd_idx;

    assign opcode  = inst[6:0];
    assign rd_idx  = inst[11:7];
    assign funct3  = inst[14:12];
    assign rs1_idx = inst[19:15];
    assign rs2_idx = inst[24:20];
    assign funct7  = inst[31:25];

    // Architectural state
    logic [XLEN-1:0] regs_q [NREG];
    logic [NREG-1:0] busy_q;
    logic [NREG-1:0] busy_d;

    // Output stage
    logic            op_valid_q, op_valid_d;
    logic [XLEN-1:0] rs1_q, rs1_d;
    logic [XLEN-1:0] rs2_q, rs2_d;
    alu_sel_e        sel_q, sel_d;
    logic [4:0]      rd_q, rd_d;
    logic            illegal_q, illegal_d;

    // Decode results
    logic     dec_legal;
    logic     dec_is_r;
    logic     dec_shift;
    alu_sel_e dec_sel;

    // Operand path
    logic [XLEN-1:0] src1_val;
    logic [XLEN-1:0] src2_val;
    logic [XLEN-1:0] imm_sext;
    logic [XLEN-1:0] imm_shamt;
    logic [XLEN-1:0] opb_val;

    // Handshake / hazard
    logic [NREG-1:0] wb_clr;
    logic [NREG-1:0] busy_set;
    logic [NREG-1:0] busy_eff;
    logic            hazard;
    logic            stage_free;
    logic            accept;
    logic            issue;
    logic            drop;

    // Decode opcode/funct3/funct7 into ALU select and legality
    always_comb begin
        dec_legal = 1'b0;
        dec_is_r  = 1'b0;
        dec_shift = 1'b0;
        dec_sel   = SEL_ADD;
        if (opcode == OPC_OP) begin
            dec_is_r = 1'b1;
            case (funct3)
                3'b000: begin
                    dec_legal = (funct7 == 7'h00) || (funct7 == 7'h20);
                    dec_sel   = funct7[5] ? SEL_SUB : SEL_ADD;
                end
                3'b111: begin dec_legal = (funct7 == 7'h00); dec_sel = SEL_AND; end
                3'b110: begin dec_legal = (funct7 == 7'h00); dec_sel = SEL_OR;  end
                3'b100: begin dec_legal = (funct7 == 7'h00); dec_sel = SEL_XOR; end
                3'b001: begin dec_legal = (funct7 == 7'h00); dec_sel = SEL_SLL; end
                3'b101: begin dec_legal = (funct7 == 7'h00); dec_sel = SEL_SRL; end
                3'b010: begin dec_legal = (funct7 == 7'h00); dec_sel = SEL_SLT; end
                default: dec_legal = 1'b0;
            endcase
        end else if (opcode == OPC_OP_IMM) begin
            case (funct3)
                3'b000: begin dec_legal = 1'b1; dec_sel = SEL_ADD; end
                3'b111: begin dec_legal = 1'b1; dec_sel = SEL_AND; end
                3'b110: begin dec_legal = 1'b1; dec_sel = SEL_OR;  end
                3'b100: begin dec_legal = 1'b1; dec_sel = SEL_XOR; end
                3'b010: begin dec_legal = 1'b1; dec_sel = SEL_SLT; end
                3'b001: begin
                    dec_legal = (funct7 == 7'h00);
                    dec_sel   = SEL_SLL;
                    dec_shift = 1'b1;
                end
                3'b101: begin
                    // funct7 0x20 here is SRAI, which this stage does not support
                    dec_legal = (funct7 == 7'h00);
                    dec_sel   = SEL_SRL;
                    dec_shift = 1'b1;
                end
                default: dec_legal = 1'b0;
            endcase
        end
    end

    // Source reads: x0 is zero, a same-cycle write-back bypasses the array
    always_comb begin
        if (rs1_idx == 5'd0) begin
            src1_val = '0;
        end else if (wb_en && (wb_rd == rs1_idx)) begin
            src1_val = wb_data;
        end else begin
            src1_val = regs_q[rs1_idx];
        end
        if (rs2_idx == 5'd0) begin
            src2_val = '0;
        end else if (wb_en && (wb_rd == rs2_idx)) begin
            src2_val = wb_data;
        end else begin
            src2_val = regs_q[rs2_idx];
        end
    end

    assign imm_sext  = {{(XLEN-12){inst[31]}}, inst[31:20]};
    assign imm_shamt = {{(XLEN-5){1'b0}}, rs2_idx};

    // Operand B: register for R-type, shift amount or sign-extended immediate otherwise
    always_comb begin
        if (dec_is_r) begin
            opb_val = src2_val;
        end else if (dec_shift) begin
            opb_val = imm_shamt;
        end else begin
            opb_val = imm_sext;
        end
    end

    // Scoreboard view: busy bits cleared by this cycle's write-back do not stall
    always_comb begin
        wb_clr   = '0;
        busy_set = '0;
        if (wb_en && (wb_rd != 5'd0)) begin
            wb_clr[wb_rd] = 1'b1;
        end
        if (issue && (rd_idx != 5'd0)) begin
            busy_set[rd_idx] = 1'b1;
        end
        busy_eff = busy_q & ~wb_clr;
        // set after clear so an issue to the register being written back stays busy
        busy_d   = busy_eff | busy_set;
    end

    // Only operands the instruction actually uses can raise a hazard
    assign hazard     = dec_legal &&
                        (busy_eff[rs1_idx] ||
                         (dec_is_r && busy_eff[rs2_idx]) ||
                         busy_eff[rd_idx]);
    assign stage_free = !op_valid_q || op_ready;
    assign inst_ready = stage_free && !hazard;
    assign accept     = inst_valid && inst_ready;
    assign issue      = accept && dec_legal;
    assign drop       = accept && !dec_legal;

    // Output stage next state: load on issue, empty on consume, otherwise hold
    always_comb begin
        op_valid_d = op_valid_q;
        rs1_d      = rs1_q;
        rs2_d      = rs2_q;
        sel_d      = sel_q;
        rd_d       = rd_q;
        illegal_d  = drop;
        if (issue) begin
            op_valid_d = 1'b1;
            rs1_d      = src1_val;
            rs2_d      = opb_val;
            sel_d      = dec_sel;
            rd_d       = rd_idx;
        end else if (op_ready) begin
            op_valid_d = 1'b0;
        end
    end

    // Output stage and illegal pulse registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            op_valid_q <= 1'b0;
            rs1_q      <= '0;
            rs2_q      <= '0;
            sel_q      <= SEL_ADD;
            rd_q       <= '0;
            illegal_q  <= 1'b0;
        end else begin
            op_valid_q <= op_valid_d;
            rs1_q      <= rs1_d;
            rs2_q      <= rs2_d;
            sel_q      <= sel_d;
            rd_q       <= rd_d;
            illegal_q  <= illegal_d;
        end
    end

    // Busy scoreboard register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            busy_q <= '0;
        end else begin
            busy_q <= busy_d;
        end
    end

    // Register file write port; x0 is never written
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int unsigned i = 0; i < NREG; i++) begin
                regs_q[i] <= '0;
            end
        end else if (wb_en && (wb_rd != 5'd0)) begin
            regs_q[wb_rd] <= wb_data;
        end
    end

    assign op_valid = op_valid_q;
    assign rs1      = rs1_q;
    assign rs2      = rs2_q;
    assign sel      = sel_q;
    assign rd_out   = rd_q;
    assign illegal  = illegal_q;

endmodule

// File: tb/tb_decod_regfile_alu.sv
// Scoreboard bench for decod_regfile_alu: directed scenarios followed by
// randomized traffic, with the bench acting as the ALU and write-back source.
module tb_decod_regfile_alu;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        inst_valid;
    logic [31:0] inst;
    logic        inst_ready;
    logic [31:0] rs1, rs2;
    logic [2:0]  sel;
    logic [4:0]  rd_out;
    logic        op_valid;
    logic        op_ready;
    logic        wb_en;
    logic [4:0]  wb_rd;
    logic [31:0] wb_data;
    logic        illegal;

    decod_regfile_alu #(.XLEN(32), .NREG(32)) dut (
        .clk(clk), .rst_n(rst_n),
        .inst_valid(inst_valid), .inst(inst), .inst_ready(inst_ready),
        .rs1(rs1), .rs2(rs2), .sel(sel), .rd_out(rd_out),
        .op_valid(op_valid), .op_ready(op_ready),
        .wb_en(wb_en), .wb_rd(wb_rd), .wb_data(wb_data),
        .illegal(illegal)
    );

    always #5 clk = ~clk;

    int unsigned cyc = 0;
    always @(posedge clk) cyc++;

    typedef struct {
        logic [31:0] a;
        logic [31:0] b;
        logic [2:0]  sel;
        logic [4:0]  rd;
        int unsigned vis;
    } op_t;

    typedef struct {
        logic [4:0]  rd;
        logic [31:0] val;
    } wb_t;

    typedef struct {
        bit          legal;
        bit          is_r;
        logic [2:0]  sel;
        logic [31:0] b_imm;
    } dec_t;

    op_t         sb[$];
    wb_t         wbq[$];
    int unsigned ill_q[$];
    logic [31:0] mregs [32];
    bit          pend [32];
    logic [2:0]  smap [8] = '{3'd0, 3'd5, 3'd7, 3'd0, 3'd4, 3'd6, 3'd3, 3'd2};

    int total = 0;
    int bad   = 0;

    task automatic check(input string name, input logic [71:0] act, input logic [71:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    function automatic dec_t model_decode(input logic [31:0] w);
        dec_t d;
        logic [6:0] opc;
        logic [2:0] f3;
        logic [6:0] f7;
        opc = w[6:0];
        f3  = w[14:12];
        f7  = w[31:25];
        d.legal = 1'b0;
        d.is_r  = 1'b0;
        d.sel   = smap[f3];
        d.b_imm = {{20{w[31]}}, w[31:20]};
        if (opc == 7'h33) begin
            d.is_r  = 1'b1;
            d.legal = (f3 != 3'd3) && ((f7 == 7'h00) || (f3 == 3'd0 && f7 == 7'h20));
            if (f3 == 3'd0 && f7 == 7'h20) d.sel = 3'd1;
        end else if (opc == 7'h13) begin
            d.legal = (f3 != 3'd3) && (!(f3 == 3'd1 || f3 == 3'd5) || f7 == 7'h00);
            if (f3 == 3'd1 || f3 == 3'd5) d.b_imm = {27'd0, w[24:20]};
        end
        return d;
    endfunction

    function automatic logic [31:0] alu(input logic [2:0] s, input logic [31:0] a, input logic [31:0] b);
        case (s)
            3'd0: return a + b;
            3'd1: return a - b;
            3'd2: return a & b;
            3'd3: return a | b;
            3'd4: return a ^ b;
            3'd5: return a << b[4:0];
            3'd6: return a >> b[4:0];
            default: return ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
        endcase
    endfunction

    function automatic logic [31:0] rand_inst();
        logic [2:0]  f3;
        logic [4:0]  r1, r2, rd;
        logic [6:0]  f7;
        logic [11:0] imm;
        logic [31:0] w;
        int unsigned k;
        f3 = 3'($urandom_range(0, 7));
        r1 = 5'($urandom_range(0, 7));
        r2 = 5'($urandom_range(0, 7));
        rd = 5'($urandom_range(0, 7));
        k  = $urandom_range(0, 9);
        if (k < 5) begin
            f7 = (f3 == 3'd0 && $urandom_range(0, 1) == 1) ? 7'h20 : 7'h00;
            w  = {f7, r2, r1, f3, rd, 7'h33};
        end else if (k < 9) begin
            imm = 12'($urandom);
            if (f3 == 3'd1 || f3 == 3'd5) imm[11:5] = 7'h00;
            w = {imm, r1, f3, rd, 7'h13};
        end else begin
            case ($urandom_range(0, 2))
                0: begin
                    w = $urandom;
                    if (w[6:0] == 7'h33 || w[6:0] == 7'h13) w[6:0] = 7'h73;
                end
                1: w = {7'h20, r2, r1, 3'b101, rd, 7'h33};
                default: w = {7'h20, r2, r1, 3'b101, rd, 7'h13};
            endcase
        end
        return w;
    endfunction

    // One clock of stimulus; entered just after a rising edge, returns just after the next.
    task automatic drive(input bit v, input logic [31:0] w, input bit ordy,
                         input bit we, input logic [4:0] wrd, input logic [31:0] wdat,
                         output bit acc, output bit rdy_seen);
        dec_t d;
        bit   haz, exp_rdy;
        logic [4:0] r1, r2, rd;
        op_t  o;
        inst_valid = v;
        inst       = w;
        op_ready   = ordy;
        wb_en      = we;
        wb_rd      = wrd;
        wb_data    = wdat;
        @(negedge clk);
        if (we && wrd != 5'd0) begin
            mregs[wrd] = wdat;
            pend[wrd]  = 1'b0;
        end
        d  = model_decode(w);
        r1 = w[19:15];
        r2 = w[24:20];
        rd = w[11:7];
        haz     = d.legal && (pend[r1] || (d.is_r && pend[r2]) || pend[rd]);
        exp_rdy = ((sb.size() == 0) || ordy) && !haz;
        rdy_seen = inst_ready;
        check("inst_ready", 72'(inst_ready), 72'(exp_rdy));
        acc = v && exp_rdy;
        if (acc) begin
            if (d.legal) begin
                o.a   = mregs[r1];
                o.b   = d.is_r ? mregs[r2] : d.b_imm;
                o.sel = d.sel;
                o.rd  = rd;
                o.vis = cyc + 1;
                sb.push_back(o);
                if (rd != 5'd0) pend[rd] = 1'b1;
            end else begin
                ill_q.push_back(cyc + 1);
            end
        end
        @(posedge clk);
        #1;
    endtask

    task automatic clear_model();
        sb.delete();
        wbq.delete();
        ill_q.delete();
        for (int i = 0; i < 32; i++) begin
            mregs[i] = '0;
            pend[i]  = 1'b0;
        end
    endtask

    task automatic drain();
        bit a, r;
        wb_t e;
        for (int i = 0; i < 300 && (sb.size() > 0 || wbq.size() > 0); i++) begin
            if (wbq.size() > 0) begin
                e = wbq.pop_front();
                drive(1'b0, 32'd0, 1'b1, 1'b1, e.rd, e.val, a, r);
            end else begin
                drive(1'b0, 32'd0, 1'b1, 1'b0, 5'd0, 32'd0, a, r);
            end
        end
        check("drain_sb", 72'(sb.size()), 72'd0);
        check("drain_wb", 72'(wbq.size()), 72'd0);
    endtask

    // Monitor: compares the presented op with the scoreboard head and plays the ALU on consume
    initial begin
        op_t o;
        bit  exp_v, exp_i;
        forever begin
            @(negedge clk);
            #1;
            if (rst_n) begin
                exp_v = (sb.size() > 0) && (sb[0].vis <= cyc);
                check("op_valid", 72'(op_valid), 72'(exp_v));
                if (op_valid && exp_v) begin
                    check("op_fields", {rs1, rs2, sel, rd_out}, {sb[0].a, sb[0].b, sb[0].sel, sb[0].rd});
                    if (op_ready) begin
                        o = sb.pop_front();
                        if (o.rd != 5'd0) wbq.push_back('{o.rd, alu(o.sel, o.a, o.b)});
                    end
                end
                while (ill_q.size() > 0 && ill_q[0] < cyc) void'(ill_q.pop_front());
                exp_i = (ill_q.size() > 0) && (ill_q[0] == cyc);
                if (exp_i) void'(ill_q.pop_front());
                check("illegal", 72'(illegal), 72'(exp_i));
            end
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL timeout: got no finish expected finish");
        $fatal(1, "timeout");
    end

    initial begin
        bit acc, rdy, v, we, have;
        logic [4:0]  wrd;
        logic [31:0] wdat, cur;
        wb_t e;
        int  acc_n;

        clear_model();
        rst_n = 1'b0;
        inst_valid = 1'b0; inst = '0; op_ready = 1'b0;
        wb_en = 1'b0; wb_rd = '0; wb_data = '0;
        repeat (2) @(posedge clk);
        #1;
        check("rst_op_valid", 72'(op_valid), 72'd0);
        check("rst_outputs", {rs1, rs2, sel, rd_out}, 72'd0);
        check("rst_illegal", 72'(illegal), 72'd0);
        rst_n = 1'b1;

        // Preload and first issue
        drive(1'b0, 32'd0, 1'b1, 1'b1, 5'd1, 32'd226, acc, rdy);
        drive(1'b0, 32'd0, 1'b1, 1'b1, 5'd2, 32'd7, acc, rdy);
        drive(1'b1, 32'h002081B3, 1'b1, 1'b0, 5'd0, 32'd0, acc, rdy);
        check("add_valid", 72'(op_valid), 72'd1);
        check("add_fields", {rs1, rs2, sel, rd_out}, {32'd226, 32'd7, 3'd0, 5'd3});
        drive(1'b1, 32'hFFF08213, 1'b1, 1'b0, 5'd0, 32'd0, acc, rdy);
        check("addi_fields", {rs1, rs2, sel, rd_out}, {32'd226, 32'hFFFFFFFF, 3'd0, 5'd4});

        // RAW stall on x3, released by a same-cycle write-back
        drive(1'b1, 32'h402182B3, 1'b1, 1'b0, 5'd0, 32'd0, acc, rdy);
        check("raw_stall", 72'(rdy), 72'd0);
        drive(1'b1, 32'h402182B3, 1'b1, 1'b1, 5'd3, 32'd233, acc, rdy);
        check("raw_release", 72'(rdy), 72'd1);
        if (wbq.size() > 0 && wbq[0].rd == 5'd3) void'(wbq.pop_front());
        check("sub_fields", {rs1, rs2, sel, rd_out}, {32'd233, 32'd7, 3'd1, 5'd5});

        // Backpressure: held op stays stable
        for (int i = 0; i < 3; i++) begin
            drive(1'b1, 32'h00208333, 1'b0, 1'b0, 5'd0, 32'd0, acc, rdy);
            check("bp_ready", 72'(rdy), 72'd0);
            check("bp_hold", {rs1, rs2, sel, rd_out}, {32'd233, 32'd7, 3'd1, 5'd5});
        end
        drive(1'b1, 32'h00208333, 1'b1, 1'b0, 5'd0, 32'd0, acc, rdy);
        check("bp_release", 72'(rdy), 72'd1);
        check("bp_next", {rs1, rs2, sel, rd_out}, {32'd226, 32'd7, 3'd0, 5'd6});

        // Illegal ECALL
        drive(1'b1, 32'h00000073, 1'b1, 1'b0, 5'd0, 32'd0, acc, rdy);
        check("ecall_ready", 72'(rdy), 72'd1);
        check("ecall_pulse", 72'(illegal), 72'd1);
        check("ecall_no_op", 72'(op_valid), 72'd0);
        drive(1'b0, 32'd0, 1'b1, 1'b0, 5'd0, 32'd0, acc, rdy);
        check("ecall_one_cycle", 72'(illegal), 72'd0);

        // Asynchronous reset while an op is held and the next one stalls
        drive(1'b1, 32'h002084B3, 1'b0, 1'b0, 5'd0, 32'd0, acc, rdy);
        drive(1'b1, 32'h00028433, 1'b0, 1'b0, 5'd0, 32'd0, acc, rdy);
        check("pre_rst_stall", 72'(rdy), 72'd0);
        #2;
        rst_n = 1'b0;
        #1;
        check("async_rst_valid", 72'(op_valid), 72'd0);
        clear_model();
        inst_valid = 1'b0;
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        drive(1'b1, 32'h00028433, 1'b1, 1'b0, 5'd0, 32'd0, acc, rdy);
        check("post_rst_ready", 72'(rdy), 72'd1);
        drive(1'b1, 32'h00108533, 1'b1, 1'b0, 5'd0, 32'd0, acc, rdy);
        check("post_rst_x1", {rs1, rs2, sel, rd_out}, {32'd0, 32'd0, 3'd0, 5'd10});
        drain();

        // Randomized traffic
        for (int r = 1; r < 32; r++) begin
            drive(1'b0, 32'd0, 1'b1, 1'b1, 5'(r), $urandom, acc, rdy);
        end
        have  = 1'b0;
        acc_n = 0;
        cur   = '0;
        for (int c = 0; c < 6000 && acc_n < 400; c++) begin
            if (!have) begin
                cur  = rand_inst();
                have = 1'b1;
            end
            we = 1'b0; wrd = '0; wdat = '0;
            if (wbq.size() > 0 && $urandom_range(0, 2) != 0) begin
                e = wbq.pop_front();
                we = 1'b1; wrd = e.rd; wdat = e.val;
            end else if ($urandom_range(0, 7) == 0) begin
                wrd = 5'($urandom_range(1, 31));
                if (!pend[wrd]) begin
                    we = 1'b1;
                    wdat = $urandom;
                end
            end
            v = ($urandom_range(0, 3) != 0);
            drive(v, cur, ($urandom_range(0, 3) != 0), we, wrd, wdat, acc, rdy);
            if (acc) begin
                have = 1'b0;
                acc_n++;
            end
        end
        drain();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
